// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data memory port arbiter
package dmem_pkg;

  localparam logic [1:0] W_BYTE  = 2'b00;
  localparam logic [1:0] W_HALF  = 2'b01;
  localparam logic [1:0] W_WORD  = 2'b10;
  localparam logic [1:0] W_DWORD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  width;
    logic        sext;
  } dmem_req_t;

endpackage

// File: rtl/dmem_starve_arb.sv
// rtl/dmem_starve_arb.sv - m0-priority grant with an m1 starvation override
module dmem_starve_arb
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic m0_valid,
  input  logic m1_valid,
  output logic grant
);

  logic [CNT_W-1:0] starve_cnt;
  logic             override;

  always_comb begin
    override = (STARVE_LIMIT != 0) && (starve_cnt >= CNT_W'(STARVE_LIMIT));
    grant    = (m1_valid && (!m0_valid || override)) ? OWN_M1 : OWN_M0;
  end

  // Counts consecutive losses of a waiting m1; any IDLE cycle without such a loss clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (m1_valid && m0_valid && (grant == OWN_M0)) begin
        if (starve_cnt != '1) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-requester arbiter for data_mem_unit port A
// One request in flight; address/width/sign stay registered until the read data is captured.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_we,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m0_wdata,
  input  logic [1:0]  m0_width,
  input  logic        m0_sext,
  output logic        m0_rsp_valid,
  output logic [63:0] m0_rdata,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_we,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m1_wdata,
  input  logic [1:0]  m1_width,
  input  logic        m1_sext,
  output logic        m1_rsp_valid,
  output logic [63:0] m1_rdata,
  output logic        mem_en,
  output logic        mem_wea,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_din,
  output logic [1:0]  mem_bit_width,
  output logic        mem_sign_extend,
  input  logic [63:0] mem_dout
);

  logic [1:0]  state;
  logic [1:0]  lat_cnt;
  logic        owner_q;
  logic        we_q;
  logic [63:0] rdata_q;
  logic        idle;
  logic        grant;
  dmem_req_t   req_sel;

  assign idle = (state == ST_IDLE) && !rst;

  dmem_starve_arb #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .idle    (idle),
    .m0_valid(m0_req_valid),
    .m1_valid(m1_req_valid),
    .grant   (grant)
  );

  assign m0_req_ready = idle && m0_req_valid && (grant == OWN_M0);
  assign m1_req_ready = idle && m1_req_valid && (grant == OWN_M1);

  always_comb begin
    req_sel = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, width: m0_width, sext: m0_sext};
    if (grant == OWN_M1)
      req_sel = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, width: m1_width, sext: m1_sext};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      lat_cnt         <= 2'd0;
      owner_q         <= OWN_M0;
      we_q            <= 1'b0;
      mem_addr        <= 64'd0;
      mem_din         <= 64'd0;
      mem_bit_width   <= W_BYTE;
      mem_sign_extend <= 1'b0;
      rdata_q         <= 64'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_req_ready || m1_req_ready) begin
            owner_q         <= grant;
            we_q            <= req_sel.we;
            mem_addr        <= req_sel.addr;
            mem_din         <= req_sel.wdata;
            mem_bit_width   <= req_sel.width;
            mem_sign_extend <= req_sel.sext;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lat_cnt <= 2'(READ_LAT - 1);
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == 2'd0) begin
            rdata_q <= we_q ? 64'd0 : mem_dout;
            state   <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en  = (state == ST_ISSUE);
  assign mem_wea = mem_en && we_q;

  assign m0_rsp_valid = (state == ST_RESP) && (owner_q == OWN_M0);
  assign m1_rsp_valid = (state == ST_RESP) && (owner_q == OWN_M1);
  assign m0_rdata     = m0_rsp_valid ? rdata_q : 64'd0;
  assign m1_rdata     = m1_rsp_valid ? rdata_q : 64'd0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
// Three instances share one stimulus: (READ_LAT,STARVE_LIMIT) = (1,4), (1,0), (2,4).
module tb_dmem_port_arbiter;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req_valid = 1'b0, m0_we = 1'b0, m0_sext = 1'b0;
  logic [63:0] m0_addr = 64'd0, m0_wdata = 64'd0;
  logic [1:0]  m0_width = 2'd0;
  logic        m1_req_valid = 1'b0, m1_we = 1'b0, m1_sext = 1'b0;
  logic [63:0] m1_addr = 64'd0, m1_wdata = 64'd0;
  logic [1:0]  m1_width = 2'd0;

  logic        m0_req_ready [NI], m1_req_ready [NI], m0_rsp_valid [NI], m1_rsp_valid [NI];
  logic        mem_en [NI], mem_wea [NI], mem_sign_extend [NI];
  logic [63:0] m0_rdata [NI], m1_rdata [NI], mem_addr [NI], mem_din [NI], mem_dout [NI];
  logic [1:0]  mem_bit_width [NI];
  logic [1:0]  rd_pipe [NI];

  function automatic int rl_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic int sl_of(input int i);
    return (i == 1) ? 0 : 4;
  endfunction

  // Bench memory content as seen through the rotate/extend logic of data_mem_unit.
  function automatic logic [63:0] mf(input logic [63:0] a, input logic [1:0] w, input logic s);
    return s ? ~(a ^ 64'h6C ^ {62'd0, w}) : ((a ^ 64'h0123_4567_89AB_CDEF) + {62'd0, w});
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_port_arbiter #(
      .READ_LAT    (g == 2 ? 2 : 1),
      .STARVE_LIMIT(g == 1 ? 0 : 4),
      .CNT_W       (3)
    ) u_dut (
      .clk(clk), .rst(rst),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready[g]), .m0_we(m0_we),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_width(m0_width), .m0_sext(m0_sext),
      .m0_rsp_valid(m0_rsp_valid[g]), .m0_rdata(m0_rdata[g]),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready[g]), .m1_we(m1_we),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_width(m1_width), .m1_sext(m1_sext),
      .m1_rsp_valid(m1_rsp_valid[g]), .m1_rdata(m1_rdata[g]),
      .mem_en(mem_en[g]), .mem_wea(mem_wea[g]), .mem_addr(mem_addr[g]), .mem_din(mem_din[g]),
      .mem_bit_width(mem_bit_width[g]), .mem_sign_extend(mem_sign_extend[g]),
      .mem_dout(mem_dout[g])
    );

    always @(posedge clk) rd_pipe[g] <= rst ? 2'b00 : {rd_pipe[g][0], mem_en[g] & ~mem_wea[g]};
    assign mem_dout[g] = (g == 2 ? rd_pipe[g][1] : rd_pipe[g][0])
                         ? mf(mem_addr[g], mem_bit_width[g], mem_sign_extend[g])
                         : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  int n_checks = 0, n_pass = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] cyc %0d: got %h, expected %h", nm, inst, cyc, act, exp);
  endtask

  // Transaction model: an accepted request fixes every later output by cycle offset.
  int          free_at [NI], acc_cyc [NI], losses [NI];
  bit          have_acc [NI], fresh [NI];
  logic        q_we [NI], q_sext [NI], q_own [NI];
  logic [63:0] q_addr [NI], q_wdata [NI];
  logic [1:0]  q_width [NI];
  logic        model_on = 1'b0;

  function automatic int exp_grant(input int i);
    if (rst || cyc < free_at[i]) return 0;
    if (m1_req_valid && (!m0_req_valid || (sl_of(i) != 0 && losses[i] >= sl_of(i)))) return 2;
    if (m0_req_valid) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        free_at[i]  <= cyc + 1;
        have_acc[i] <= 1'b0;
        fresh[i]    <= 1'b1;
        losses[i]   <= 0;
      end else begin
        if (cyc >= free_at[i]) begin
          if (m1_req_valid && exp_grant(i) == 1) losses[i] <= (losses[i] < 7) ? losses[i] + 1 : 7;
          else losses[i] <= 0;
        end
        if (exp_grant(i) != 0) begin
          q_own[i]    <= (exp_grant(i) == 2);
          q_we[i]     <= (exp_grant(i) == 2) ? m1_we : m0_we;
          q_addr[i]   <= (exp_grant(i) == 2) ? m1_addr : m0_addr;
          q_wdata[i]  <= (exp_grant(i) == 2) ? m1_wdata : m0_wdata;
          q_width[i]  <= (exp_grant(i) == 2) ? m1_width : m0_width;
          q_sext[i]   <= (exp_grant(i) == 2) ? m1_sext : m0_sext;
          acc_cyc[i]  <= cyc;
          have_acc[i] <= 1'b1;
          fresh[i]    <= 1'b0;
          free_at[i]  <= cyc + 3 + rl_of(i);
        end
      end
    end
    if (rst) model_on <= 1'b1;
    cyc <= cyc + 1;
  end

  task automatic check_inst(input int i);
    int d;
    logic e_en, e_r0, e_r1;
    logic [63:0] e_rd;
    d    = cyc - acc_cyc[i];
    e_en = have_acc[i] && d == 1;
    e_r0 = have_acc[i] && d == 2 + rl_of(i) && q_own[i] == 1'b0;
    e_r1 = have_acc[i] && d == 2 + rl_of(i) && q_own[i] == 1'b1;
    e_rd = q_we[i] ? 64'd0 : mf(q_addr[i], q_width[i], q_sext[i]);
    chk("m0_req_ready", i, 64'(m0_req_ready[i]), 64'(exp_grant(i) == 1));
    chk("m1_req_ready", i, 64'(m1_req_ready[i]), 64'(exp_grant(i) == 2));
    chk("mem_en", i, 64'(mem_en[i]), 64'(e_en));
    chk("mem_wea", i, 64'(mem_wea[i]), 64'(e_en && q_we[i]));
    chk("m0_rsp_valid", i, 64'(m0_rsp_valid[i]), 64'(e_r0));
    chk("m1_rsp_valid", i, 64'(m1_rsp_valid[i]), 64'(e_r1));
    if (e_r0) chk("m0_rdata", i, m0_rdata[i], e_rd);
    if (e_r1) chk("m1_rdata", i, m1_rdata[i], e_rd);
    if (have_acc[i] && d >= 1 && d <= 1 + rl_of(i)) begin
      chk("mem_addr_held", i, mem_addr[i], q_addr[i]);
      chk("mem_width_held", i, 64'(mem_bit_width[i]), 64'(q_width[i]));
      chk("mem_sext_held", i, 64'(mem_sign_extend[i]), 64'(q_sext[i]));
      chk("mem_din_held", i, mem_din[i], q_wdata[i]);
    end else if (fresh[i]) begin
      chk("reset_mem_addr", i, mem_addr[i], 64'd0);
      chk("reset_mem_din", i, mem_din[i], 64'd0);
      chk("reset_mem_width", i, 64'(mem_bit_width[i]), 64'd0);
      chk("reset_mem_sext", i, 64'(mem_sign_extend[i]), 64'd0);
      chk("reset_m0_rdata", i, m0_rdata[i], 64'd0);
      chk("reset_m1_rdata", i, m1_rdata[i], 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < NI; i++) check_inst(i);
    end
  end

  // Event log used by the directed literal checks.
  int          rsp0_n [NI], rsp0_cyc [NI], rsp1_n [NI], en_n [NI], en_cyc [NI], wea_n [NI], gn [NI];
  logic [63:0] rsp0_dat [NI], rsp1_dat [NI], wea_din [NI];
  int          gseq [NI][256];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (m0_rsp_valid[i] === 1'b1) begin
        rsp0_n[i] <= rsp0_n[i] + 1; rsp0_cyc[i] <= cyc; rsp0_dat[i] <= m0_rdata[i];
      end
      if (m1_rsp_valid[i] === 1'b1) begin
        rsp1_n[i] <= rsp1_n[i] + 1; rsp1_dat[i] <= m1_rdata[i];
      end
      if (mem_en[i] === 1'b1) begin
        en_n[i] <= en_n[i] + 1; en_cyc[i] <= cyc;
      end
      if (mem_wea[i] === 1'b1) begin
        wea_n[i] <= wea_n[i] + 1; wea_din[i] <= mem_din[i];
      end
      if (gn[i] < 256) begin
        if (m0_req_valid && m0_req_ready[i] === 1'b1) begin
          gseq[i][gn[i]] <= 1; gn[i] <= gn[i] + 1;
        end else if (m1_req_valid && m1_req_ready[i] === 1'b1) begin
          gseq[i][gn[i]] <= 2; gn[i] <= gn[i] + 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t, e0, r1a, w0, nm1;
    int gb [NI];
    int r0b [NI];

    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_idle_mem_addr", 0, mem_addr[0], 64'd0);
    chk("reset_idle_mem_en", 0, 64'(mem_en[0]), 64'd0);

    // Load byte @0x13 with sign extension.
    m0_we = 1'b0; m0_addr = 64'h13; m0_width = 2'b00; m0_sext = 1'b1; m0_req_valid = 1'b1;
    t = cyc; e0 = en_n[0]; r1a = rsp1_n[0];
    tick(1);
    m0_req_valid = 1'b0;
    tick(7);
    chk("t1_en_count", 0, 64'(en_n[0] - e0), 64'd1);
    chk("t1_en_cycle", 0, 64'(en_cyc[0]), 64'(t + 1));
    chk("t1_rsp_cycle", 0, 64'(rsp0_cyc[0]), 64'(t + 3));
    chk("t1_rdata", 0, rsp0_dat[0], 64'hFFFF_FFFF_FFFF_FF80);
    chk("t1_rsp_cycle", 2, 64'(rsp0_cyc[2]), 64'(t + 4));
    chk("t1_rdata", 2, rsp0_dat[2], 64'hFFFF_FFFF_FFFF_FF80);
    chk("t1_no_m1_rsp", 0, 64'(rsp1_n[0] - r1a), 64'd0);

    // Store dword @0x8.
    m0_we = 1'b1; m0_addr = 64'h8; m0_wdata = 64'h1122_3344_5566_7788; m0_width = 2'b11;
    m0_sext = 1'b0; m0_req_valid = 1'b1;
    t = cyc; w0 = wea_n[0];
    tick(1);
    m0_req_valid = 1'b0; m0_we = 1'b0;
    tick(7);
    chk("t2_wea_count", 0, 64'(wea_n[0] - w0), 64'd1);
    chk("t2_wea_din", 0, wea_din[0], 64'h1122_3344_5566_7788);
    chk("t2_rsp_cycle", 0, 64'(rsp0_cyc[0]), 64'(t + 3));
    chk("t2_rdata", 0, rsp0_dat[0], 64'd0);

    // Both requesters valid continuously.
    m0_addr = 64'h100; m0_width = 2'b10; m0_sext = 1'b0; m0_req_valid = 1'b1;
    m1_we = 1'b0; m1_addr = 64'h204; m1_width = 2'b01; m1_sext = 1'b1; m1_req_valid = 1'b1;
    for (int i = 0; i < NI; i++) gb[i] = gn[i];
    tick(60);
    for (int k = 0; k < 10; k++) begin
      chk("starve_order", 0, 64'(gseq[0][gb[0] + k]), 64'((k % 5 == 4) ? 2 : 1));
      chk("starve_order", 2, 64'(gseq[2][gb[2] + k]), 64'((k % 5 == 4) ? 2 : 1));
    end
    nm1 = 0;
    for (int k = gb[1]; k < gn[1]; k++) if (gseq[1][k] == 2) nm1++;
    chk("strict_no_m1", 1, 64'(nm1), 64'd0);
    chk("strict_m0_grants", 1, 64'(gn[1] - gb[1] >= 10), 64'd1);
    gb[1] = gn[1];
    m0_req_valid = 1'b0;
    tick(6);
    chk("strict_m1_after_drop", 1, 64'(gseq[1][gb[1]]), 64'd2);
    m1_req_valid = 1'b0;
    tick(8);

    // Reset while the load sits in WAIT; m1 store waits across reset.
    m0_we = 1'b0; m0_addr = 64'h40; m0_width = 2'b10; m0_sext = 1'b0; m0_req_valid = 1'b1;
    for (int i = 0; i < NI; i++) r0b[i] = rsp0_n[i];
    r1a = rsp1_n[0];
    tick(1);
    m0_req_valid = 1'b0;
    tick(1);
    rst = 1'b1;
    m1_we = 1'b1; m1_addr = 64'h30; m1_wdata = 64'hCAFE; m1_width = 2'b11; m1_sext = 1'b0;
    m1_req_valid = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("rst_mem_addr", 0, mem_addr[0], 64'd0);
    chk("rst_mem_en", 0, 64'(mem_en[0]), 64'd0);
    chk("rst_m0_rsp", 0, 64'(m0_rsp_valid[0]), 64'd0);
    chk("rst_m1_ready", 0, 64'(m1_req_ready[0]), 64'd1);
    tick(1);
    m1_req_valid = 1'b0; m1_we = 1'b0;
    tick(8);
    for (int i = 0; i < NI; i++) chk("rst_aborted_rsp", i, 64'(rsp0_n[i] - r0b[i]), 64'd0);
    chk("rst_m1_rsp_count", 0, 64'(rsp1_n[0] - r1a), 64'd1);
    chk("rst_m1_rdata", 0, rsp1_dat[0], 64'd0);

    // Requester changes its fields right after acceptance.
    m0_we = 1'b0; m0_addr = 64'h5A; m0_width = 2'b01; m0_sext = 1'b1; m0_req_valid = 1'b1;
    t = cyc;
    tick(1);
    m0_req_valid = 1'b0; m0_addr = 64'h999; m0_width = 2'b11; m0_sext = 1'b0;
    tick(8);
    chk("t5_rsp_cycle", 2, 64'(rsp0_cyc[2]), 64'(t + 4));
    chk("t5_rdata", 2, rsp0_dat[2], 64'hFFFF_FFFF_FFFF_FFC8);
    chk("t5_rsp_cycle", 0, 64'(rsp0_cyc[0]), 64'(t + 3));
    chk("t5_rdata", 0, rsp0_dat[0], 64'hFFFF_FFFF_FFFF_FFC8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
